// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle FP operator among NREQ requesters.
// Operands are captured at grant so requesters may change their inputs while the operation is in flight.
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    op_a,
    input  logic [NREQ*WIDTH-1:0]    op_b,
    output logic [NREQ-1:0]          done,
    output logic [WIDTH-1:0]         result,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     unit_start,
    output logic [WIDTH-1:0]         unit_a,
    output logic [WIDTH-1:0]         unit_b,
    input  logic [WIDTH-1:0]         unit_result,
    input  logic                     unit_ready
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic found;
    int   pick;
    int   idx;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        found   = 1'b0;
        pick    = 0;
        idx     = 0;

        // First requester at or after the round-robin pointer, wrapping modulo NREQ.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = IDW'(pick);
                    a_d     = op_a[pick*WIDTH +: WIDTH];
                    b_d     = op_b[pick*WIDTH +: WIDTH];
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (unit_ready) begin
                    res_d   = unit_result;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // All outputs are pure decodes of registered state.
    assign busy       = (state_q != S_IDLE);
    assign unit_start = (state_q == S_ISSUE);
    assign unit_a     = (state_q == S_ISSUE || state_q == S_WAIT) ? a_q : '0;
    assign unit_b     = (state_q == S_ISSUE || state_q == S_WAIT) ? b_q : '0;
    assign done       = (state_q == S_DONE) ? (NREQ'(1) << grant_q) : '0;
    assign result     = (state_q == S_DONE) ? res_q : '0;
    assign err        = (state_q == S_DONE) && err_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: a transaction-level round-robin model and a fake
// operator push expected completions; an independent monitor pops them on every done pulse.
module tb_fpu_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 12;
    localparam int IDW     = $clog2(NREQ);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   op_a, op_b;
    logic [NREQ-1:0]         done;
    logic [WIDTH-1:0]        result;
    logic                    err, busy;
    logic [IDW-1:0]          grant_id;
    logic                    unit_start;
    logic [WIDTH-1:0]        unit_a, unit_b, unit_result;
    logic                    unit_ready;

    fpu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .result(result), .err(err), .busy(busy), .grant_id(grant_id),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_result(unit_result), .unit_ready(unit_ready)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] res;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model and stimulus state
    int               mptr = 0;
    bit               op_on = 0;
    int               op_j = 0, op_k = 0;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] lat_a, lat_b;
    int               force_k = 0;
    bit               force_res_en = 0;
    logic [WIDTH-1:0] force_res = '0;
    bit               rand_en = 0, hungry = 0;
    int               hungry_n = 0, last_g = -1;
    int               n_start = 0;
    logic [NREQ-1:0]  seen_done;
    int               seen_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock of stimulus: operator model, arbitration reference, requester behaviour.
    task automatic step();
        int g;
        @(negedge clk);
        seen_done = done;
        seen_cyc  = cycle;

        if (unit_start === 1'b1) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
            check("start_has_request", 64'(g >= 0), 64'(1));
            if (g < 0) g = 0;
            if (hungry) begin
                if (hungry_n >= 2) check("rr_order", 64'(g), 64'((last_g + 1) % NREQ));
                hungry_n++;
            end
            last_g = g;
            lat_a = op_a[g*WIDTH +: WIDTH];
            lat_b = op_b[g*WIDTH +: WIDTH];
            check("grant_id", 64'(grant_id), 64'(g));
            check("issue_unit_a", 64'(unit_a), 64'(lat_a));
            check("issue_unit_b", 64'(unit_b), 64'(lat_b));
            mptr = (g + 1) % NREQ;
            if (force_k != 0) op_k = force_k;
            else begin
                case ($urandom_range(0, 9))
                    0:       op_k = TIMEOUT + 3;
                    1:       op_k = TIMEOUT;
                    default: op_k = $urandom_range(1, 5);
                endcase
            end
            op_res = force_res_en ? force_res : WIDTH'($urandom);
            op_j   = 0;
            op_on  = 1;
            sb.push_back('{id: g,
                           res: (op_k <= TIMEOUT) ? op_res : '0,
                           err: (op_k > TIMEOUT),
                           cyc: cycle + 1 + ((op_k <= TIMEOUT) ? op_k : TIMEOUT)});
            n_start++;
            unit_ready  = 1'b0;
            unit_result = WIDTH'($urandom);
        end else if (op_on) begin
            op_j++;
            check("wait_unit_a", 64'(unit_a), 64'(lat_a));
            check("wait_unit_b", 64'(unit_b), 64'(lat_b));
            check("start_single_cycle", 64'(unit_start), 64'(0));
            unit_ready  = (op_j == op_k);
            unit_result = (op_j == op_k) ? op_res : WIDTH'($urandom);
            if (op_j == op_k || op_j >= TIMEOUT) op_on = 0;
        end else begin
            unit_ready  = 1'b1;
            unit_result = WIDTH'($urandom);
        end

        for (int i = 0; i < NREQ; i++) begin
            if (done[i]) req[i] = 1'b0;
            else if (!req[i]) begin
                if (hungry || (rand_en && $urandom_range(0, 3) == 0)) begin
                    req[i] = 1'b1;
                    op_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    op_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end else if (rand_en && $urandom_range(0, 49) == 0) begin
                req[i] = 1'b0;
            end
        end
        if ((rand_en || hungry) && op_on && $urandom_range(0, 2) == 0) begin
            g = $urandom_range(0, NREQ - 1);
            op_a[g*WIDTH +: WIDTH] = WIDTH'($urandom);
            op_b[g*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    task automatic run_until_done(input int maxc, output int at, output logic [NREQ-1:0] who);
        at  = -1;
        who = '0;
        for (int n = 0; n < maxc && at < 0; n++) begin
            step();
            if (seen_done != '0) begin
                at  = seen_cyc;
                who = seen_done;
            end
        end
        check("done_within_bound", 64'(at >= 0), 64'(1));
    endtask

    // Waits one IDLE cycle, then raises a single request; returns the cycle it was raised.
    task automatic issue(input int i, input int k, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, output int c0);
        step();
        force_k = k;
        req[i]  = 1'b1;
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
        c0 = cycle;
    endtask

    // Monitor: decoupled from stimulus, compares every done pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done !== '0) begin
                check("done_onehot", 64'($onehot(done)), 64'(1));
                if (sb.size() == 0) check("unexpected_done", 64'(done), 64'(0));
                else begin
                    e = sb.pop_front();
                    check("done_id", 64'(done), 64'(1) << e.id);
                    check("result", 64'(result), 64'(e.res));
                    check("err", 64'(err), 64'(e.err));
                    check("done_cycle", 64'(cycle), 64'(e.cyc));
                end
            end else begin
                check("err_outside_done", 64'(err), 64'(0));
                if (sb.size() > 0 && cycle > sb[0].cyc) begin
                    check("done_missing", 64'(cycle), 64'(sb[0].cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               c0, at, cnt;
        logic [NREQ-1:0]  who;
        rst = 1'b0; req = '0; op_a = '0; op_b = '0; unit_ready = 1'b1; unit_result = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_start", 64'(unit_start), 64'(0));
        check("rst_unit_a", 64'(unit_a), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        rst = 1'b1;

        // Single request, operator ready after 5 WAIT cycles with result 3.0
        force_res_en = 1; force_res = 32'h40400000;
        cnt = n_start;
        issue(0, 5, 32'h3f800000, 32'h40000000, c0);
        run_until_done(40, at, who);
        check("s1_who", 64'(who), 64'(4'b0001));
        check("s1_latency", 64'(at - c0), 64'(7));
        check("s1_one_start", 64'(n_start - cnt), 64'(1));
        force_res_en = 0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin step(); if (seen_done != '0) cnt++; end
        check("s1_no_second_done", 64'(cnt), 64'(0));

        // Minimum latency: ready in the first WAIT cycle
        issue(1, 1, 32'h12345678, 32'h9abcdef0, c0);
        run_until_done(20, at, who);
        check("min_who", 64'(who), 64'(4'b0010));
        check("min_latency", 64'(at - c0), 64'(3));

        // Timeout, then a normal request is served
        issue(2, TIMEOUT + 3, 32'h11111111, 32'h22222222, c0);
        run_until_done(TIMEOUT + 20, at, who);
        check("to_who", 64'(who), 64'(4'b0100));
        check("to_latency", 64'(at - c0), 64'(TIMEOUT + 2));
        issue(3, 2, 32'h33333333, 32'h44444444, c0);
        run_until_done(20, at, who);
        check("after_to_who", 64'(who), 64'(4'b1000));
        check("after_to_latency", 64'(at - c0), 64'(4));

        // Operand of the granted requester changes mid-WAIT
        issue(0, 6, 32'h0badf00d, 32'hcafef00d, c0);
        repeat (3) step();
        op_a[0 +: WIDTH] = 32'hdeadbeef;
        op_b[0 +: WIDTH] = 32'hfeedface;
        run_until_done(20, at, who);
        check("opchg_who", 64'(who), 64'(4'b0001));
        force_k = 0;

        // Randomized traffic, then all requesters continuously requesting
        rand_en = 1;
        repeat (1500) step();
        rand_en = 0; hungry = 1; hungry_n = 0;
        repeat (300) step();
        hungry = 0;
        for (int n = 0; n < 2000 && !(req == '0 && sb.size() == 0 && !busy && !op_on); n++) step();
        check("drained", 64'(req == '0 && sb.size() == 0 && !busy), 64'(1));

        // Reset during WAIT of requester 2
        issue(2, TIMEOUT + 3, 32'h55555555, 32'h66666666, c0);
        for (int n = 0; n < 30 && !(op_on && op_j >= 2); n++) step();
        check("reached_wait", 64'(op_on && op_j >= 2), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_unit_a", 64'(unit_a), 64'(0));
        sb.delete();
        op_on = 0; mptr = 0; unit_ready = 1'b1;
        req[0] = 1'b1;
        op_a[0 +: WIDTH] = 32'h77777777;
        op_b[0 +: WIDTH] = 32'h88888888;
        repeat (2) @(negedge clk);
        check("inrst_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        force_k = 2;
        run_until_done(20, at, who);
        check("post_rst_first", 64'(who), 64'(4'b0001));
        run_until_done(20, at, who);
        check("post_rst_second", 64'(who), 64'(4'b0100));
        repeat (4) step();
        check("final_scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesting kernels (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width (IEEE single-precision bits).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before the operation is aborted.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port req, input, NREQ bits: requester i asks for one operation, held high until done[i].
REQ-007 The block SHALL have port op_a, input, NREQ*WIDTH bits: operand A of requester i in slice [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port op_b, input, NREQ*WIDTH bits: operand B, packed as op_a.
REQ-009 The block SHALL have port done, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port result, output, WIDTH bits: result, valid while any done bit is high.
REQ-011 The block SHALL have port err, output, 1 bit: high with done when the operation timed out.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port grant_id, output, clog2(NREQ) bits: index of the current or last granted requester.
REQ-014 The block SHALL have ports unit_start (output, 1), unit_a (output, WIDTH), unit_b (output, WIDTH), unit_result (input, WIDTH) and unit_ready (input, 1), driving one shared multi-cycle FP operator (sp_mulF32/sp_addF32 class).

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; all outputs SHALL decode from registered state.
REQ-016 In IDLE, if any req bit is high, the block SHALL grant the first requester found at or after pointer ptr (modulo NREQ), latch that requester's op_a/op_b slices and its index, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 In ISSUE, unit_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT with the wait counter cleared.
REQ-018 unit_a and unit_b SHALL present the latched operands, stable from ISSUE through the last WAIT cycle; they SHALL be 0 in IDLE.
REQ-019 In WAIT, unit_ready SHALL be sampled every cycle. The operator contract is: ready is deasserted from the cycle after start until its result is valid. Ready=1 SHALL latch unit_result and go to DONE.
REQ-020 In WAIT, the counter SHALL increment each cycle without ready; on the cycle it equals TIMEOUT-1 with ready=0, the block SHALL go to DONE with err latched 1 and the result latched 0.
REQ-021 In DONE, done[grant_id] SHALL be 1 for one cycle, with result and err valid; ptr SHALL become (grant_id+1) mod NREQ; the next state SHALL be IDLE.
REQ-022 Minimum latency SHALL be 4 cycles from the IDLE cycle that sees req to the done pulse (ready in the first WAIT cycle); in general it is 3 + the number of WAIT cycles.
REQ-023 The requester SHALL drop req on the edge where it samples done. A req that is deasserted before done SHALL be ignored; the in-flight operation still completes and pulses done.
REQ-024 Round-robin SHALL guarantee that, with all requesters continuously requesting, each is served once per NREQ operations.
REQ-025 Changes on req or op_* while busy SHALL NOT affect the in-flight operation.
REQ-026 err SHALL be 0 outside DONE, and done SHALL be all-zero outside DONE.

Reset
REQ-027 While rst=0 (asynchronous), the block SHALL set state=IDLE, ptr=0, grant_id=0, counter=0, and latched operands, result and err to 0. Outputs: done=0, unit_start=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL abandon it with no done pulse; after release, the first grant SHALL start search at index 0.

Verification
REQ-029 Scenario: req=0001, operator ready 5 cycles after start, unit_result=0x40400000 -> one unit_start pulse, done=0001 exactly once, result=0x40400000, err=0.
REQ-030 Scenario: req=1111 held continuously, each requester re-requests after its done -> grant order 0,1,2,3,0,... and no two done bits high together.
REQ-031 Scenario: operator never raises ready -> done to the requester after TIMEOUT WAIT cycles with err=1 and result=0; next request is served normally.
REQ-032 Scenario: ready in the first WAIT cycle -> done 4 cycles after req is first seen in IDLE; operands on unit_a/unit_b match the requester's slices.
REQ-033 Scenario: rst pulsed low during WAIT of requester 2 -> no done, busy=0 immediately; after release with req=0100|0001, requester 0 is granted first.
REQ-034 Scenario: op_a of the granted requester changed during WAIT -> unit_a stays at the value latched in IDLE.
